bcd_step_counter: RTL and testbench

Two-digit BCD up/down counter driving the 4-bit BCD inputs of the seven-segment decoders (ones digit to HEX0, tens digit to HEX1). It advances on a prescaled timebase tick when enabled, or once per debounced press of a pushbutton. It also supports synchronous parallel load of the ones digit and flags wrap-around. Every output is registered, so the downstream decoders see glitch-free BCD.

---
 rtl/bcd_defs_pkg.sv | 23 ++
 rtl/step_debounce.sv | 93 +++++++++
 rtl/bcd_step_counter.sv | 106 ++++++++++
 tb/tb_bcd_step_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_defs_pkg.sv
// rtl/bcd_defs_pkg.sv - shared BCD constants, debounce state encodings and width helper
package bcd_defs;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - pushbutton synchroniser and debounce FSM producing one pulse per press
module step_debounce
    import bcd_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pulse
);

    localparam int            TW     = clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timer_done;

    // Flops idle high so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    assign timer_done = (timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (timer_clr) begin
                timer <= '0;
            end else if (!timer_done) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync_2) begin
                    state_nxt = PRESS_WAIT;
                    timer_clr = 1'b1;
                end
            end
            PRESS_WAIT: begin
                if (sync_2) begin
                    state_nxt = RELEASED;
                end else if (timer_done) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (sync_2) begin
                    state_nxt = RELEASE_WAIT;
                    timer_clr = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_2) begin
                    state_nxt = PRESSED;
                end else if (timer_done) begin
                    state_nxt = RELEASED;
                end
            end
            default: state_nxt = RELEASED;
        endcase
    end

    // The pulse fires only on the single PRESS_WAIT -> PRESSED transition.
    always_comb begin
        pulse = 1'b0;
        if (state == PRESS_WAIT && !sync_2 && timer_done) begin
            pulse = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_step_counter.sv
// rtl/bcd_step_counter.sv - two-digit BCD up/down counter with timebase, step button, load and wrap flag
module bcd_step_counter
    import bcd_defs::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic       UP,
    input  logic       STEP_N,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] BCD_ONES,
    output logic [3:0] BCD_TENS,
    output logic       WRAP
);

    localparam int            DIV    = CLK_HZ / TICK_HZ;
    localparam int            PW     = clog2(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic          step_pulse;
    logic          advance;
    logic [3:0]    ones_nxt;
    logic [3:0]    tens_nxt;
    logic          wrap_nxt;

    // Free-running timebase; EN only gates whether its tick is used.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
        end else if (presc == P_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == P_LAST);

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .btn_n (STEP_N),
        .pulse (step_pulse)
    );

    // OR rather than sum: a tick and a step in the same cycle count once.
    assign advance = (EN & tick) | step_pulse;

    always_comb begin
        ones_nxt = BCD_ONES;
        tens_nxt = BCD_TENS;
        wrap_nxt = 1'b0;
        if (LOAD) begin
            ones_nxt = (LOAD_VAL > BCD_MAX) ? BCD_MAX : LOAD_VAL;
            tens_nxt = 4'd0;
        end else if (advance) begin
            if (UP) begin
                if (BCD_ONES < BCD_MAX) begin
                    ones_nxt = BCD_ONES + 4'd1;
                end else begin
                    ones_nxt = 4'd0;
                    if (BCD_TENS < BCD_MAX) begin
                        tens_nxt = BCD_TENS + 4'd1;
                    end else begin
                        tens_nxt = 4'd0;
                        wrap_nxt = 1'b1;
                    end
                end
            end else begin
                if (BCD_ONES > 4'd0) begin
                    ones_nxt = BCD_ONES - 4'd1;
                end else begin
                    ones_nxt = BCD_MAX;
                    if (BCD_TENS > 4'd0) begin
                        tens_nxt = BCD_TENS - 4'd1;
                    end else begin
                        tens_nxt = BCD_MAX;
                        wrap_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            BCD_ONES <= 4'd0;
            BCD_TENS <= 4'd0;
            WRAP     <= 1'b0;
        end else begin
            BCD_ONES <= ones_nxt;
            BCD_TENS <= tens_nxt;
            WRAP     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb/tb_bcd_step_counter.sv - scoreboard bench for bcd_step_counter
module tb_bcd_step_counter;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       EN;
    logic       UP;
    logic       STEP_N;
    logic       LOAD;
    logic [3:0] LOAD_VAL;
    logic [3:0] BCD_ONES;
    logic [3:0] BCD_TENS;
    logic       WRAP;

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q[$];
    logic [7:0] prev_digits = 8'h00;
    logic       mon_en = 1'b0;
    logic [8:0] mon_got;
    logic [8:0] mon_want;
    int         ph = 0;
    int         bounce[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_step_counter #(
        .CLK_HZ(20),
        .TICK_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .EN       (EN),
        .UP       (UP),
        .STEP_N   (STEP_N),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .BCD_ONES (BCD_ONES),
        .BCD_TENS (BCD_TENS),
        .WRAP     (WRAP)
    );

    // Timebase phase as the design should see it: 19 marks the tick cycle.
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) ph <= 0;
        else ph <= (ph == 19) ? 0 : ph + 1;
    end

    always @(negedge CLOCK_50) begin
        mon_got = {BCD_TENS, BCD_ONES, WRAP};
        if (mon_en && (mon_got[8:1] != prev_digits || WRAP === 1'b1)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL output_event: got=%h%h wrap=%b want=no change", BCD_TENS, BCD_ONES, WRAP);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    bad++;
                    $display("FAIL sequence: got=%h%h wrap=%b want=%h%h wrap=%b",
                             mon_got[8:5], mon_got[4:1], mon_got[0],
                             mon_want[8:5], mon_want[4:1], mon_want[0]);
                end
            end
        end
        prev_digits = mon_got[8:1];
    end

    task automatic push(input int t, input int o, input int w);
        exp_q.push_back({4'(t), 4'(o), 1'(w)});
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLOCK_50);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got=%0d pending outputs want=0 within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; EN = 1'b0; UP = 1'b1; STEP_N = 1'b1; LOAD = 1'b0; LOAD_VAL = 4'd0;
        cyc(3);
        check("reset_ones", int'(BCD_ONES), 0);
        check("reset_tens", int'(BCD_TENS), 0);
        check("reset_wrap", int'(WRAP), 0);
        RESET_N = 1'b1;
        mon_en = 1'b1;

        // Full up-count 00..99,00 with a single wrap.
        EN = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i == 100) push(0, 0, 1);
            else push(i / 10, i % 10, 0);
        end
        drain(2100, "count_up");

        // Down from 00 wraps to 99, then 98.
        UP = 1'b0;
        push(9, 9, 1);
        push(9, 8, 0);
        drain(60, "count_down");
        EN = 1'b0;

        // Bounces no longer than 3 cycles are ignored.
        foreach (bounce[i]) begin
            STEP_N = bounce[i][0];
            cyc(1);
        end
        cyc(12);
        check("bounce_hold", int'({BCD_TENS, BCD_ONES}), 'h98);

        // Long press: one increment, visible 7 cycles after the fall.
        UP = 1'b1;
        push(9, 9, 0);
        STEP_N = 1'b0;
        cyc(6);
        check("press_latency_early", int'({BCD_TENS, BCD_ONES}), 'h98);
        cyc(1);
        check("press_latency_on", int'({BCD_TENS, BCD_ONES}), 'h99);
        cyc(43);
        STEP_N = 1'b1;
        cyc(12);
        drain(5, "press");

        // Step pulse coincident with an enabled tick advances once.
        LOAD = 1'b1; LOAD_VAL = 4'd5;
        push(0, 5, 0);
        cyc(1);
        LOAD = 1'b0;
        drain(5, "load_5");
        for (int i = 0; i < 40 && ph != 13; i++) cyc(1);
        EN = 1'b1; STEP_N = 1'b0;
        push(0, 6, 0);
        cyc(7);
        EN = 1'b0;
        cyc(5);
        STEP_N = 1'b1;
        cyc(12);
        drain(5, "tick_step_merge");

        // Count to 42, then loads.
        EN = 1'b1;
        for (int v = 7; v <= 42; v++) push(v / 10, v % 10, 0);
        drain(800, "count_42");
        EN = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 4'd7;
        push(0, 7, 0);
        cyc(1);
        LOAD_VAL = 4'd12;
        push(0, 9, 0);
        cyc(1);
        LOAD_VAL = 4'd0;
        push(0, 0, 0);
        cyc(1);
        LOAD = 1'b0;
        drain(5, "load_values");

        // Load beats a coincident down-tick from 00 that would otherwise wrap.
        for (int i = 0; i < 40 && ph != 19; i++) cyc(1);
        UP = 1'b0; EN = 1'b1; LOAD = 1'b1; LOAD_VAL = 4'd3;
        push(0, 3, 0);
        cyc(1);
        LOAD = 1'b0; EN = 1'b0;
        drain(5, "load_over_advance");

        // Count to 57, reset mid-debounce.
        UP = 1'b1; EN = 1'b1;
        for (int v = 4; v <= 57; v++) push(v / 10, v % 10, 0);
        drain(1200, "count_57");
        EN = 1'b0;
        STEP_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #2;
        push(0, 0, 0);
        RESET_N = 1'b0;
        #1;
        check("async_reset_ones", int'(BCD_ONES), 0);
        check("async_reset_tens", int'(BCD_TENS), 0);
        check("async_reset_wrap", int'(WRAP), 0);
        STEP_N = 1'b1;
        cyc(2);
        RESET_N = 1'b1;
        cyc(20);
        check("no_stale_pulse", int'({BCD_TENS, BCD_ONES}), 'h00);
        push(0, 1, 0);
        STEP_N = 1'b0;
        cyc(10);
        STEP_N = 1'b1;
        cyc(12);
        drain(5, "fresh_press");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
